// File: rtl/rtc_bcd_time_editor.sv
// rtc_bcd_time_editor
//   BCD time-set editor sitting between the key debouncers and the RTC writer.
//   Captures N_FIELDS packed BCD fields into a shadow register, edits the
//   selected field with wrapping up/down steps, and commits with a one-cycle
//   write strobe. While editing it requests a clock halt (edit_active_o) and
//   blinks the selected field's two digits via blank_mask_o.
//
//   Optional feature macro: RTC_EDIT_TIMEOUT_EN
//     When defined, an idle counter aborts the edit (no write) after
//     TIMEOUT_CYC key-less cycles in EDIT. When undefined, EDIT persists
//     until key_mode_i and TIMEOUT_CYC is unused.
//
// Ports
//   clk_i          system clock
//   rst_n_i        asynchronous active-low reset
//   key_mode_i     1-cycle pulse: enter edit / commit
//   key_sel_i      1-cycle pulse: select next lower field (wraps 0 -> N_FIELDS-1)
//   key_inc_i      1-cycle pulse: increment selected field
//   key_dec_i      1-cycle pulse: decrement selected field
//   rd_time_i      live BCD fields from the RTC reader
//   wr_time_o      shadow fields, valid while edit_active_o or wr_valid_o
//   wr_valid_o     1-cycle commit strobe
//   edit_active_o  high in EDIT and COMMIT
//   sel_field_o    index of the selected field
//   blank_mask_o   1 = blank digit, bits [2i+1:2i] belong to field i
module rtc_bcd_time_editor #(
  parameter int                     N_FIELDS    = 3,
  parameter logic [N_FIELDS*8-1:0]  FIELD_MAX   = 24'h235959,
  parameter logic [N_FIELDS*8-1:0]  FIELD_MIN   = 24'h000000,
  parameter int                     BLINK_DIV   = 12_499_999,
  parameter int                     TIMEOUT_CYC = 500_000_000,
  localparam int                    SEL_W       = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    key_mode_i,
  input  logic                    key_sel_i,
  input  logic                    key_inc_i,
  input  logic                    key_dec_i,
  input  logic [N_FIELDS*8-1:0]   rd_time_i,
  output logic [N_FIELDS*8-1:0]   wr_time_o,
  output logic                    wr_valid_o,
  output logic                    edit_active_o,
  output logic [SEL_W-1:0]        sel_field_o,
  output logic [2*N_FIELDS-1:0]   blank_mask_o
);

  localparam int               BLINK_W   = (BLINK_DIV < 1) ? 1 : $clog2(BLINK_DIV + 1);
  localparam logic [BLINK_W-1:0] BLINK_TOP = BLINK_W'(BLINK_DIV);
  localparam logic [SEL_W-1:0]   SEL_TOP   = SEL_W'(N_FIELDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT} state_e;

  state_e                  state_q, state_d;
  logic [N_FIELDS*8-1:0]   shadow_q, shadow_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                    phase_q, phase_d;
  logic                    timeout_hit;

  // Priority decode: only the winning key acts.
  logic act_sel, act_inc, act_dec, any_key;
  assign act_sel = !key_mode_i && key_sel_i;
  assign act_inc = !key_mode_i && !key_sel_i && key_inc_i;
  assign act_dec = !key_mode_i && !key_sel_i && !key_inc_i && key_dec_i;
  assign any_key = key_mode_i | key_sel_i | key_inc_i | key_dec_i;

  // One wrapping BCD step. Values with a non-decimal nibble or above the
  // field maximum snap to MIN (up) or MAX (down).
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] mx,
                                           input logic [7:0] mn, input logic up);
    logic illegal;
    illegal = (v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v > mx);
    if (up) begin
      if (illegal || v >= mx)   bcd_step = mn;
      else if (v[3:0] == 4'd9)  bcd_step = {v[7:4] + 4'd1, 4'd0};
      else                      bcd_step = {v[7:4], v[3:0] + 4'd1};
    end else begin
      if (illegal || v <= mn)   bcd_step = mx;
      else if (v[3:0] == 4'd0)  bcd_step = {v[7:4] - 4'd1, 4'd9};
      else                      bcd_step = {v[7:4], v[3:0] - 4'd1};
    end
  endfunction

`ifdef RTC_EDIT_TIMEOUT_EN
  localparam int              TO_W   = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_TOP = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] idle_q, idle_d;

  assign timeout_hit = (state_q == S_EDIT) && !any_key && (idle_q == TO_TOP);

  // Counts key-less EDIT cycles; zero on entry to EDIT and on any key.
  always_comb begin
    idle_d = '0;
    if (state_q == S_EDIT && !any_key && !timeout_hit) idle_d = idle_q + TO_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) idle_q <= '0;
    else          idle_q <= idle_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (key_mode_i) state_d = S_EDIT;
      S_EDIT: begin
        if (key_mode_i)       state_d = S_COMMIT;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    edit_active_o = (state_q != S_IDLE);
    wr_valid_o    = (state_q == S_COMMIT);
    wr_time_o     = shadow_q;
    sel_field_o   = sel_q;
    blank_mask_o  = '0;
    for (int i = 0; i < N_FIELDS; i++)
      blank_mask_o[2*i +: 2] = (state_q == S_EDIT && phase_q && sel_q == SEL_W'(i)) ? 2'b11 : 2'b00;
  end

  // Shadow, selection and blink datapath
  always_comb begin
    shadow_d    = shadow_q;
    sel_d       = sel_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    unique case (state_q)
      S_IDLE: begin
        if (key_mode_i) begin
          shadow_d    = rd_time_i;
          sel_d       = SEL_TOP;
          blink_cnt_d = '0;
          phase_d     = 1'b0;
        end
      end
      S_EDIT: begin
        if (timeout_hit) begin
          shadow_d = '0;
        end else if (key_mode_i) begin
          // commit: shadow held for the strobe cycle
        end else if (act_sel) begin
          sel_d       = (sel_q == '0) ? SEL_TOP : sel_q - SEL_W'(1);
          blink_cnt_d = '0;
          phase_d     = 1'b0;
        end else if (act_inc || act_dec) begin
          for (int i = 0; i < N_FIELDS; i++)
            if (sel_q == SEL_W'(i))
              shadow_d[i*8 +: 8] = bcd_step(shadow_q[i*8 +: 8], FIELD_MAX[i*8 +: 8],
                                            FIELD_MIN[i*8 +: 8], act_inc);
          blink_cnt_d = '0;
          phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_TOP) begin
          blink_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shadow_q    <= '0;
      sel_q       <= SEL_TOP;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      sel_q       <= sel_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

endmodule
